mem_stage: RTL

Memory-access stage of the RV32 core, directly downstream of the ALU/execute stage. Takes the execute result bundle, issues byte/halfword/word loads and stores to data memory over a req/ack handshake, and aligns and extends load data. Presents a registered writeback bundle with the selected write-back value to the register file write port.

---
 rtl/mem_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage; issues loads/stores over a req/ack handshake and registers the writeback bundle.
// Ports: clk/rst (sync, active-high); execute bundle valid_i/pc_i/alu_res_i/rs2data_i/funct3_i/memren_i/memwren_i/wbsel_i/rd_i/regwren_i;
//        stall_o back to execute; dmem_req_o/we_o/addr_o/be_o/wdata_o/rdata_i/ack_i to data memory;
//        writeback bundle valid_o/rd_o/regwren_o/wbdata_o/misalign_o.
// Define MEM_STAGE_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  input  logic [2:0]        funct3_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [1:0]        wbsel_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              valid_o,
  output logic [4:0]        rd_o,
  output logic              regwren_o,
  output logic [DWIDTH-1:0] wbdata_o,
  output logic              misalign_o
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [DWIDTH-1:0] alu_q, alu_d, wdata_q, wdata_d, wb_q, wb_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] sel_q, sel_d;
  logic [4:0] lrd_q, lrd_d, rd_q, rd_d;
  logic [3:0] be_q, be_d;
  logic lwen_q, lwen_d, we_q, we_d, valid_q, valid_d, wen_q, wen_d, mis_q, mis_d;
  logic [1:0] off;
  logic mem_op, mis;
  logic [3:0] be_in;
  logic [DWIDTH-1:0] wdata_in, ld;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  function automatic logic [DWIDTH-1:0] wb_mux(input logic [1:0] sel, input logic [DWIDTH-1:0] alu,
                                               input logic [AWIDTH-1:0] pc, input logic [DWIDTH-1:0] ldv);
    return sel == 2'd1 ? ldv : sel == 2'd2 ? DWIDTH'(pc + AWIDTH'(4)) : alu;
  endfunction

  assign off    = alu_res_i[1:0];
  assign mem_op = memren_i | memwren_i;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign mis = mem_op & (funct3_i[1] ? |off : funct3_i[0] & off[0]);
`else
  assign mis = 1'b0;
`endif
  assign be_in    = funct3_i[1] ? 4'hf : funct3_i[0] ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
  assign wdata_in = funct3_i[1] ? rs2data_i : funct3_i[0] ? {2{rs2data_i[15:0]}} : {4{rs2data_i[7:0]}};
  // funct3[2] set means unsigned load
  assign ld_byte = dmem_rdata_i[{alu_q[1:0], 3'b000} +: 8];
  assign ld_half = alu_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign ld      = f3_q[1] ? dmem_rdata_i :
                   f3_q[0] ? {{16{~f3_q[2] & ld_half[15]}}, ld_half} : {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    f3_d    = f3_q;
    sel_d   = sel_q;
    lrd_d   = lrd_q;
    lwen_d  = lwen_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    rd_d    = rd_q;
    wen_d   = wen_q;
    wb_d    = wb_q;
    mis_d   = mis_q;
    if (state_q == IDLE && valid_i && (!mem_op || mis)) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      wen_d   = regwren_i & ~mis;
      wb_d    = wb_mux(wbsel_i, alu_res_i, pc_i, alu_res_i);
      mis_d   = mis;
    end else if (state_q == IDLE && valid_i) begin
      state_d = REQ;
      pc_d    = pc_i;
      alu_d   = alu_res_i;
      f3_d    = funct3_i;
      sel_d   = wbsel_i;
      lrd_d   = rd_i;
      lwen_d  = regwren_i;
      we_d    = memwren_i;
      addr_d  = {alu_res_i[AWIDTH-1:2], 2'b00};
      be_d    = be_in;
      wdata_d = wdata_in;
    end else if (state_q == REQ && dmem_ack_i) begin
      state_d = IDLE;
      valid_d = 1'b1;
      rd_d    = lrd_q;
      wen_d   = lwen_q;
      wb_d    = wb_mux(sel_q, alu_q, pc_q, ld);
      mis_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      alu_q   <= '0;
      f3_q    <= '0;
      sel_q   <= '0;
      lrd_q   <= '0;
      lwen_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      f3_q    <= f3_d;
      sel_q   <= sel_d;
      lrd_q   <= lrd_d;
      lwen_q  <= lwen_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
    end
  end

  assign stall_o      = state_q == REQ;
  assign dmem_req_o   = state_q == REQ;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign valid_o      = valid_q;
  assign rd_o         = rd_q;
  assign regwren_o    = wen_q;
  assign wbdata_o     = wb_q;
  assign misalign_o   = mis_q;
endmodule
